// File: rtl/csr_exc_ctrl.sv
// csr_exc_ctrl: LoongArch CSR file with exception/ertn sequencing, interrupt
// sampling and the countdown timer. The timer (TCFG/TVAL/TICLR, ESTAT.IS[11])
// is only built when CSR_EXC_CTRL_TIMER_EN is defined.
module csr_exc_ctrl #(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_ex,
  input  logic        ws_ertn,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_vaddr,
  input  logic [13:0] csr_num,
  input  logic        csr_we,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rvalue,
  input  logic [7:0]  hw_int,
  input  logic        ipi_int,
  output logic        has_int,
  output logic [31:0] ex_entry,
  output logic [31:0] ertn_pc,
  output logic [31:0] tid_rvalue
);

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ECFG   = 14'h04;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [8:0] ESUB_ADEF = 9'h000;

  logic [3:0]  crmd_q;
  logic [2:0]  prmd_q;
  logic [12:0] lie_q;
  logic [12:0] is_q, is_d;
  logic [5:0]  ecode_q;
  logic [8:0]  esub_q;
  logic [31:0] era_q, badv_q, tid_q;
  logic [25:0] eentry_q;
  logic [31:0] save_q [4];
  logic        has_int_q;
  logic        timer_is_d;
  logic [31:0] tcfg_rd, tval_rd;

  // Software writes are dropped whenever an exception or ertn commits
  logic        wr_en;
  logic [31:0] keep, wbits;
  logic        badv_pc, badv_va;

  assign wr_en   = csr_we & ~ws_ex & ~ws_ertn;
  assign keep    = ~csr_wmask;
  assign wbits   = csr_wdata & csr_wmask;
  assign badv_pc = (ws_ecode == ECODE_ADE) && (ws_esubcode == ESUB_ADEF);
  assign badv_va = (ws_ecode == ECODE_ALE) ||
                   ((ws_ecode == ECODE_ADE) && (ws_esubcode != ESUB_ADEF));

`ifdef CSR_EXC_CTRL_TIMER_EN
  logic [31:0] tcfg_q, tcnt_q, tcnt_d, tcfg_new;
  logic        tcfg_wr, ticlr, expire;

  assign tcfg_wr  = wr_en && (csr_num == CSR_TCFG);
  assign ticlr    = wr_en && (csr_num == CSR_TICLR) && csr_wdata[0] && csr_wmask[0];
  assign tcfg_new = (tcfg_q & keep) | wbits;
  assign expire   = tcfg_q[0] && (tcnt_q == '0);

  // Counter next state; a TCFG write restarts from the new InitVal
  always_comb begin
    tcnt_d = tcnt_q;
    if (tcfg_wr) begin
      tcnt_d = {tcfg_new[31:2], 2'b00};
    end else if (tcfg_q[0] && (tcnt_q != '1)) begin
      if (expire) tcnt_d = tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : '1;
      else        tcnt_d = tcnt_q - 32'd1;
    end
  end

  // Expiry beats a same-cycle TICLR so a tick is never lost
  assign timer_is_d = expire ? 1'b1 : (ticlr ? 1'b0 : is_q[11]);

  // Timer configuration and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q <= '0;
      tcnt_q <= '1;
    end else begin
      if (tcfg_wr) tcfg_q <= tcfg_new;
      tcnt_q <= tcnt_d;
    end
  end

  assign tcfg_rd = tcfg_q;
  assign tval_rd = tcnt_q;
`else
  assign timer_is_d = 1'b0;
  assign tcfg_rd    = '0;
  assign tval_rd    = '0;
`endif

  // ESTAT.IS next state: hardware lines sampled every cycle, IS[1:0] software
  always_comb begin
    is_d      = is_q;
    is_d[9:2] = hw_int;
    is_d[10]  = 1'b0;
    is_d[11]  = timer_is_d;
    is_d[12]  = ipi_int;
    if (wr_en && (csr_num == CSR_ESTAT)) is_d[1:0] = (is_q[1:0] & keep[1:0]) | wbits[1:0];
  end

  // CRMD/PRMD: exception saves and clears PLV/IE, ertn restores them
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_q <= 4'h8;
      prmd_q <= '0;
    end else if (ws_ex) begin
      prmd_q      <= crmd_q[2:0];
      crmd_q[2:0] <= '0;
    end else if (ws_ertn) begin
      crmd_q[2:0] <= prmd_q;
    end else if (wr_en) begin
      if (csr_num == CSR_CRMD) crmd_q <= (crmd_q & keep[3:0]) | wbits[3:0];
      if (csr_num == CSR_PRMD) prmd_q <= (prmd_q & keep[2:0]) | wbits[2:0];
    end
  end

  // ESTAT cause fields, ERA and BADV capture on exception
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      is_q    <= '0;
      ecode_q <= '0;
      esub_q  <= '0;
      era_q   <= '0;
      badv_q  <= '0;
    end else begin
      is_q <= is_d;
      if (ws_ex) begin
        ecode_q <= ws_ecode;
        esub_q  <= ws_esubcode;
        era_q   <= ws_pc;
        if (badv_pc)      badv_q <= ws_pc;
        else if (badv_va) badv_q <= ws_vaddr;
      end else if (wr_en) begin
        if (csr_num == CSR_ERA)  era_q  <= (era_q & keep) | wbits;
        if (csr_num == CSR_BADV) badv_q <= (badv_q & keep) | wbits;
      end
    end
  end

  // Plain software-owned registers: ECFG, EENTRY, SAVE0-3, TID
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lie_q    <= '0;
      eentry_q <= '0;
      tid_q    <= TID_INIT;
      for (int unsigned i = 0; i < 4; i++) save_q[i] <= '0;
    end else if (wr_en) begin
      if (csr_num == CSR_ECFG)   lie_q    <= (lie_q & keep[12:0]) | (wbits[12:0] & 13'h1BFF);
      if (csr_num == CSR_EENTRY) eentry_q <= (eentry_q & keep[31:6]) | wbits[31:6];
      if (csr_num == CSR_TID)    tid_q    <= (tid_q & keep) | wbits;
      if (csr_num[13:2] == CSR_SAVE0[13:2])
        save_q[csr_num[1:0]] <= (save_q[csr_num[1:0]] & keep) | wbits;
    end
  end

  // Pending-interrupt flag registered from current IE/IS/LIE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) has_int_q <= 1'b0;
    else         has_int_q <= crmd_q[2] & (|(is_q & lie_q));
  end

  // CSR read port
  always_comb begin
    csr_rvalue = '0;
    case (csr_num)
      CSR_CRMD:   csr_rvalue = {28'b0, crmd_q};
      CSR_PRMD:   csr_rvalue = {29'b0, prmd_q};
      CSR_ECFG:   csr_rvalue = {19'b0, lie_q};
      CSR_ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'b0, is_q};
      CSR_ERA:    csr_rvalue = era_q;
      CSR_BADV:   csr_rvalue = badv_q;
      CSR_EENTRY: csr_rvalue = {eentry_q, 6'b0};
      CSR_SAVE0:  csr_rvalue = save_q[0];
      CSR_SAVE1:  csr_rvalue = save_q[1];
      CSR_SAVE2:  csr_rvalue = save_q[2];
      CSR_SAVE3:  csr_rvalue = save_q[3];
      CSR_TID:    csr_rvalue = tid_q;
      CSR_TCFG:   csr_rvalue = tcfg_rd;
      CSR_TVAL:   csr_rvalue = tval_rd;
      default:    csr_rvalue = '0;
    endcase
  end

  assign has_int    = has_int_q;
  assign ex_entry   = {eentry_q, 6'b0};
  assign ertn_pc    = era_q;
  assign tid_rvalue = tid_q;

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Self-checking bench for csr_exc_ctrl: a register-array reference model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_csr_exc_ctrl;

`ifdef CSR_EXC_CTRL_TIMER_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif
  localparam logic [31:0] TIDV = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_ex, ws_ertn;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic [31:0] ws_pc, ws_vaddr;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wdata, csr_rvalue;
  logic [7:0]  hw_int;
  logic        ipi_int;
  logic        has_int;
  logic [31:0] ex_entry, ertn_pc, tid_rvalue;

  int checks = 0;
  int errors = 0;

  csr_exc_ctrl #(.TID_INIT(TIDV)) dut (
    .clk(clk), .resetn(resetn), .ws_ex(ws_ex), .ws_ertn(ws_ertn),
    .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode), .ws_pc(ws_pc),
    .ws_vaddr(ws_vaddr), .csr_num(csr_num), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rvalue(csr_rvalue),
    .hw_int(hw_int), .ipi_int(ipi_int), .has_int(has_int),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .tid_rvalue(tid_rvalue)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_csr [128];
  logic [31:0] m_tcnt;
  logic        m_has;

  function automatic logic [31:0] wmask_of(int n);
    case (n)
      0:              return 32'h0000_000F;
      1:              return 32'h0000_0007;
      4:              return 32'h0000_1BFF;
      5:              return 32'h0000_0003;
      6, 7:           return 32'hFFFF_FFFF;
      12:             return 32'hFFFF_FFC0;
      48, 49, 50, 51: return 32'hFFFF_FFFF;
      64:             return 32'hFFFF_FFFF;
      65:             return TE ? 32'hFFFF_FFFF : 32'h0;
      default:        return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(logic [13:0] num);
    int n;
    n = int'(num);
    if (n >= 128) return 32'h0;
    if (n == 66) return TE ? m_tcnt : 32'h0;
    if (n == 5 || wmask_of(n) != 0) return m_csr[n];
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_csr[i] = 32'h0;
    m_csr[0]  = 32'h8;
    m_csr[64] = TIDV;
    m_tcnt    = 32'hFFFF_FFFF;
    m_has     = 1'b0;
  endtask

  task automatic m_step();
    logic [31:0] tc, wm;
    logic        expire, tcfg_w, clr, nh;
    int          n;
    nh     = m_csr[0][2] && ((m_csr[5][12:0] & m_csr[4][12:0]) != 13'h0);
    tc     = m_csr[65];
    expire = TE && tc[0] && (m_tcnt == 32'h0);
    tcfg_w = 1'b0;
    clr    = 1'b0;
    n      = int'(csr_num);
    if (ws_ex) begin
      m_csr[1] = m_csr[0] & 32'h7;
      m_csr[0] = m_csr[0] & 32'h8;
      m_csr[6] = ws_pc;
      m_csr[5][30:16] = {ws_esubcode, ws_ecode};
      if (ws_ecode == 6'h08 && ws_esubcode == 9'h0) m_csr[7] = ws_pc;
      else if (ws_ecode == 6'h09 || ws_ecode == 6'h08) m_csr[7] = ws_vaddr;
    end else if (ws_ertn) begin
      m_csr[0] = (m_csr[0] & 32'h8) | m_csr[1];
    end else if (csr_we && n < 128) begin
      wm = wmask_of(n) & csr_wmask;
      m_csr[n] = (m_csr[n] & ~wm) | (csr_wdata & wm);
      tcfg_w = TE && (n == 65);
      clr    = TE && (n == 68) && csr_wdata[0] && csr_wmask[0];
    end
    m_csr[5][9:2] = hw_int;
    m_csr[5][12]  = ipi_int;
    if (tcfg_w) m_tcnt = {m_csr[65][31:2], 2'b00};
    else if (TE && tc[0] && m_tcnt != 32'hFFFF_FFFF)
      m_tcnt = (m_tcnt == 32'h0) ? (tc[1] ? {tc[31:2], 2'b00} : 32'hFFFF_FFFF) : m_tcnt - 32'd1;
    if (expire) m_csr[5][11] = 1'b1;
    else if (clr) m_csr[5][11] = 1'b0;
    m_has = nh;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_reset();
    else         m_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rvalue", csr_rvalue, m_read(csr_num));
    chk("has_int", {31'b0, has_int}, {31'b0, m_has});
    chk("ex_entry", ex_entry, m_csr[12]);
    chk("ertn_pc", ertn_pc, m_csr[6]);
    chk("tid", tid_rvalue, m_csr[64]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [13:0] num, logic [31:0] data, logic [31:0] mask);
    csr_num = num; csr_we = 1'b1; csr_wdata = data; csr_wmask = mask;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic rd(string name, logic [13:0] num, logic [31:0] exp);
    csr_num = num;
    #1;
    chk(name, csr_rvalue, exp);
  endtask

  logic [13:0] nums [16] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
                             14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h03};

  initial begin
    logic [31:0] r;
    m_reset();
    resetn = 1'b0; ws_ex = 0; ws_ertn = 0; ws_ecode = '0; ws_esubcode = '0;
    ws_pc = '0; ws_vaddr = '0; csr_num = '0; csr_we = 0; csr_wmask = '0;
    csr_wdata = '0; hw_int = '0; ipi_int = 0;
    #12 resetn = 1'b1;
    rd("reset_crmd", 14'h00, 32'h8);
    chk("reset_tid", tid_rvalue, TIDV);
    chk("reset_ex_entry", ex_entry, 32'h0);
    chk("reset_has_int", {31'b0, has_int}, 32'h0);
    tick();

    // exception then ertn
    wr(14'h00, 32'h7, 32'hFFFF_FFFF);
    wr(14'h0C, 32'h1C00_8000, 32'hFFFF_FFFF);
    ws_ex = 1; ws_ecode = 6'h0B; ws_esubcode = '0; ws_pc = 32'h1C00_0100;
    tick();
    ws_ex = 0;
    rd("ex_prmd", 14'h01, 32'h7);
    rd("ex_crmd", 14'h00, 32'h0);
    rd("ex_era", 14'h06, 32'h1C00_0100);
    rd("ex_estat", 14'h05, 32'h000B_0000);
    chk("ex_entry_lit", ex_entry, 32'h1C00_8000);
    chk("ertn_pc_lit", ertn_pc, 32'h1C00_0100);
    ws_ertn = 1;
    tick();
    ws_ertn = 0;
    rd("ertn_crmd", 14'h00, 32'h7);

    // ADEF takes the PC, ALE takes the data address and drops the same-cycle write
    ws_ex = 1; ws_ecode = 6'h08; ws_esubcode = 9'h0; ws_pc = 32'h1C00_0300; ws_vaddr = 32'h55;
    tick();
    ws_ex = 0;
    rd("adef_badv", 14'h07, 32'h1C00_0300);
    wr(14'h30, 32'h1234_5678, 32'hFFFF_FFFF);
    ws_ex = 1; ws_ecode = 6'h09; ws_esubcode = 9'h0; ws_pc = 32'h1C00_0200; ws_vaddr = 32'h13;
    csr_we = 1; csr_num = 14'h30; csr_wdata = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF;
    tick();
    ws_ex = 0; csr_we = 0;
    rd("ale_badv", 14'h07, 32'h13);
    rd("ale_save0", 14'h30, 32'h1234_5678);

    // masked ESTAT write with IE=0
    wr(14'h04, 32'h3, 32'hFFFF_FFFF);
    wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("estat_masked", 14'h05, 32'h0009_0003);
    tick(); tick();
    chk("ie0_has_int", {31'b0, has_int}, 32'h0);
    wr(14'h05, 32'h0, 32'hFFFF_FFFF);
    wr(14'h04, 32'h0, 32'hFFFF_FFFF);

    if (TE) begin
      wr(14'h04, 32'h800, 32'hFFFF_FFFF);
      wr(14'h00, 32'h4, 32'h4);
      wr(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
      rd("tval_start", 14'h42, 32'h8);
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (k == 9) begin
          rd("timer_is_set", 14'h05, 32'h0009_0800);
          chk("has_int_pre", {31'b0, has_int}, 32'h0);
        end
        if (k == 10) chk("has_int_rise", {31'b0, has_int}, 32'h1);
      end
      wr(14'h44, 32'h1, 32'h1);
      rd("ticlr_is", 14'h05, 32'h0009_0000);
      tick();
      chk("has_int_drop", {31'b0, has_int}, 32'h0);
      for (int k = 0; k < 6; k++) tick();
      rd("timer_period", 14'h05, 32'h0009_0800);
      for (int k = 0; k < 8; k++) tick();
      wr(14'h44, 32'h1, 32'h1);
      rd("clr_vs_expiry", 14'h05, 32'h0009_0800);
      wr(14'h41, 32'h0, 32'hFFFF_FFFF);
      wr(14'h44, 32'h1, 32'h1);
      wr(14'h00, 32'h0, 32'h4);
    end else begin
      wr(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
      rd("tcfg_absent", 14'h41, 32'h0);
      rd("tval_absent", 14'h42, 32'h0);
    end

    // randomized traffic checked by the every-cycle compare
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      ws_ex   = (r < 6);
      ws_ertn = (r >= 6 && r < 10);
      case ($urandom_range(0, 3))
        0: ws_ecode = 6'h08;
        1: ws_ecode = 6'h09;
        2: ws_ecode = 6'h0B;
        default: begin r = $urandom; ws_ecode = r[5:0]; end
      endcase
      r = $urandom;
      ws_esubcode = ($urandom_range(0, 1) == 0) ? 9'h0 : r[8:0];
      ws_pc = $urandom; ws_vaddr = $urandom;
      r = $urandom;
      csr_num = (r[3:0] == 4'h0) ? r[17:4] : nums[r[7:4]];
      csr_we = ($urandom_range(0, 2) == 0);
      csr_wdata = $urandom;
      csr_wmask = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
      if (csr_num == 14'h41) begin
        csr_wdata = ($urandom_range(0, 12) << 2) | $urandom_range(0, 3);
        csr_wmask = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom; hw_int = r[7:0]; ipi_int = r[8];
      end
      tick();
    end
    ws_ex = 0; ws_ertn = 0; csr_we = 0;

    // asynchronous reset in mid-cycle
    #3 resetn = 1'b0;
    rd("async_crmd", 14'h00, 32'h8);
    chk("async_has_int", {31'b0, has_int}, 32'h0);
    rd("async_tval", 14'h42, TE ? 32'hFFFF_FFFF : 32'h0);
    #1 resetn = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_exc_ctrl.md
# csr_exc_ctrl

Exception, interrupt and timer controller owning the architectural control/status registers of the LoongArch pipeline. Receives commit-time exception and ertn events from the writeback stage, sequences the CRMD/PRMD/ERA/ESTAT/BADV updates, and supplies the flush target PC to fetch. Hosts the countdown timer and interrupt sampling, and returns the pending-interrupt flag to decode. Serves the single CSR read/write port used by csrrd/csrwr/csrxchg.

## Interface
- TID_INIT, 32'h0, reset value of TID (0x40)
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- ws_ex  in  1  exception committing in writeback this cycle
- ws_ertn  in  1  ertn committing this cycle (never together with ws_ex)
- ws_ecode  in  6  exception code
- ws_esubcode  in  9  exception subcode
- ws_pc  in  32  PC of the committing instruction
- ws_vaddr  in  32  faulting data address
- csr_num  in  14  CSR index, read and write
- csr_we  in  1  CSR write strobe
- csr_wmask  in  32  bit write mask
- csr_wdata  in  32  write data
- csr_rvalue  out  32  combinational read data of csr_num
- hw_int  in  8  hardware interrupt lines, level
- ipi_int  in  1  inter-processor interrupt, level
- has_int  out  1  enabled interrupt pending
- ex_entry  out  32  EENTRY, exception target
- ertn_pc  out  32  ERA, ertn target
- tid_rvalue  out  32  TID for rdcntid

## Operation
- Registers (index): CRMD 0x0 {DA[3],IE[2],PLV[1:0]}; PRMD 0x1 {PIE[2],PPLV[1:0]}; ECFG 0x4 LIE {12:11,9:0}; ESTAT 0x5 {EsubCode[30:22],Ecode[21:16],IS[12:0]}; ERA 0x6; BADV 0x7; EENTRY 0xC [31:6]; SAVE0–3 0x30–0x33; TID 0x40; TCFG 0x41 {InitVal[31:2],Periodic[1],En[0]}; TVAL 0x42 read-only; TICLR 0x44 write-only, reads 0.
- Unlisted indices read 0, writes ignored. Unimplemented bits read 0. Only ESTAT.IS[1:0] are software-writable in ESTAT.
- Write: reg <= (reg & ~wmask) | (wdata & wmask) on implemented bits.
- Exception (ws_ex): PPLV<=PLV, PIE<=IE, PLV<=0, IE<=0, ERA<=ws_pc, Ecode/EsubCode<=inputs.
  - BADV<=ws_pc when ecode=ADE with esubcode=ADEF.
  - BADV<=ws_vaddr when ecode=ALE, or ADE with any other esubcode.
  - csr_we in the same cycle is discarded.
- ertn (ws_ertn): PLV<=PPLV, IE<=PIE; same-cycle csr_we discarded.
- IS[9:2]<=hw_int and IS[12]<=ipi_int, sampled every cycle (one-cycle register delay).
- has_int = IE & |(IS & LIE), from registered state only.
- Timer counter tcnt (TVAL), 32 bits:
  - Write to TCFG: tcnt <= {new InitVal,2'b00}.
  - Otherwise, when En=1 and tcnt != 32'hFFFFFFFF: tcnt <= tcnt-1.
  - On the En=1, tcnt==0 cycle: IS[11]<=1; tcnt reloads {InitVal,2'b00} if Periodic, else wraps to all-ones and stops.
- TICLR write with wdata[0]&wmask[0] clears IS[11]. A same-cycle expiry wins: IS[11] stays 1.

## Timing
- Reset values: CRMD=0x8; TID=TID_INIT; tcnt=32'hFFFFFFFF; all other state 0; has_int=0.
- Resulting outputs: ex_entry=0, ertn_pc=0, tid_rvalue=TID_INIT.
- All updates land at the clk edge of the event cycle; csr_rvalue, ex_entry and ertn_pc reflect them the next cycle.
- A read of the register being written in the same cycle returns the old value.
- Timer period with InitVal=N, Periodic=1: IS[11] is set 4N+1 cycles after the TCFG write, then every 4N+1 cycles.
- Interrupt latency: hw_int rise to has_int = 2 cycles (sample, then IS).
- Reset mid-count clears the timer immediately and asynchronously; no pending interrupt survives reset.

## Configuration
- CSR_EXC_CTRL_TIMER_EN defined: TCFG/TVAL/TICLR and IS[11] behave as specified.
- Undefined: TCFG, TVAL and TICLR read 0 and ignore writes; IS[11] is constant 0; no counter logic is synthesized.

## Test plan
- Reset: drop resetn mid-cycle → CRMD reads 0x8, TVAL reads 0xFFFFFFFF, has_int=0 without waiting for a clock edge.
- Exception + ertn:
  - Setup: CRMD=0x7, EENTRY=0x1C008000.
  - Stimulus: ws_ex with ecode 0x0B, ws_pc=0x1C000100.
  - Required after exception: PRMD=0x7, CRMD[2:0]=0, ERA=0x1C000100, ESTAT[21:16]=0x0B, ex_entry=0x1C008000.
  - Then ertn → CRMD[2:0]=0x7.
- ALE: ecode 0x09 with ws_vaddr=0x00000013 → BADV=0x13. Same cycle csr_we to SAVE0 → SAVE0 unchanged.
- Timer:
  - Write TCFG=0x0000000B (InitVal=2, periodic, enabled), ECFG=0x800, CRMD.IE=1.
  - has_int rises 10 cycles after the write (IS[11] set at 9 + 1).
  - TICLR=1 → has_int drops; IS[11] sets again 9 cycles later.
- Simultaneous clear/expiry: TICLR write on the expiry cycle → IS[11]=1 afterwards.
- Masked write: ESTAT write wdata=0xFFFFFFFF, wmask=0xFFFFFFFF → only IS[1:0]=0x3 change. IE=0 with LIE=0x3 → has_int stays 0.
